// File: rtl/uart_led_pkg.sv
// Shared constants and types for the UART-LED display path.
//   CHAR_BLANK  : character shown on unused digits (ASCII space)
//   ANODE_OFF   : all four active-low anodes released
//   NUM_DIGITS  : digits in the multiplexed display
//   BUF_DEPTH   : entries in the circular message buffer
//   scan_state_t: phase inside one digit slot (all-off blanking, then drive)
package uart_led_pkg;

  localparam logic [7:0] CHAR_BLANK = 8'h20;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam int         NUM_DIGITS = 4;
  localparam int         BUF_DEPTH  = 16;

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_t;

endpackage

// File: rtl/msg_buffer.sv
// 16x8 message storage: one synchronous write port, one combinational
// read port. Contents are data only and are not reset; the owner tracks
// which entries are valid.
//   clock : system clock
//   we    : write enable
//   waddr : write index
//   wdata : byte to store
//   raddr : read index
//   rdata : byte at raddr (combinational)
module msg_buffer
  import uart_led_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [BUF_DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_display_scheduler.sv
// Drives a 4-digit multiplexed LED display from received UART bytes.
// Bytes land in a 16-entry circular buffer (oldest entry overwritten when
// full); the four anodes are scanned with a blanking gap at the start of
// every slot, and messages longer than four characters scroll as a marquee.
//   clock, reset     : system clock, asynchronous active-low reset
//   rx_data/valid/error : received byte, strobe, and error qualifier
//   clear            : synchronous buffer/flag clear (wins over a write)
//   scroll_en        : enables marquee scrolling
//   anode            : active-low digit enables, anode[3] = leftmost digit
//   char_out         : character for the digit in its slot
//   char_valid       : high while an anode is driven
//   buf_count        : stored characters, 0..16
//   overflow         : sticky, a write hit a full buffer
//   error_flag       : sticky, a byte arrived with rx_error set
module uart_display_scheduler #(
  parameter int SCAN_DIV   = 16,
  parameter int BLANK      = 2,
  parameter int SCROLL_DIV = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  input  logic       clear,
  input  logic       scroll_en,
  output logic [3:0] anode,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic [4:0] buf_count,
  output logic       overflow,
  output logic       error_flag
);
  import uart_led_pkg::*;

  localparam logic [15:0] PSC_LAST    = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_W     = 16'(BLANK);
  localparam logic [15:0] SCROLL_LAST = 16'(SCROLL_DIV - 1);

  logic [3:0]  wr_ptr, rd_ptr;
  logic [4:0]  count;
  logic        full, we;
  logic [15:0] psc, psc_nxt;
  logic [1:0]  digit, digit_nxt;
  logic [15:0] frame_cnt, frame_nxt;
  logic [4:0]  offset, offset_nxt;
  scan_state_t state, state_nxt;
  logic        slot_wrap, frame_wrap, scroll_act;
  logic [3:0]  anode_nxt;
  logic        char_valid_nxt;
  logic [4:0]  sel_sum;
  logic [3:0]  sel_idx, rd_addr;
  logic [7:0]  rd_data, char_nxt;

  assign full      = (count == 5'(BUF_DEPTH));
  assign we        = rx_valid && !rx_error && !clear;
  assign buf_count = count;

  msg_buffer u_buf (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Write path: pointers, occupancy and sticky flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      error_flag <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      error_flag <= 1'b0;
    end else if (rx_valid) begin
      if (rx_error) begin
        error_flag <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + 4'd1;
        if (full) begin
          rd_ptr   <= rd_ptr + 4'd1;
          overflow <= 1'b1;
        end else begin
          count <= count + 5'd1;
        end
      end
    end
  end

  // Next scan position, phase, marquee offset and the character to latch
  always_comb begin
    slot_wrap  = (psc == PSC_LAST);
    frame_wrap = slot_wrap && (digit == 2'd3);
    psc_nxt    = slot_wrap ? '0 : psc + 16'd1;
    digit_nxt  = slot_wrap ? digit + 2'd1 : digit;
    state_nxt  = (psc_nxt < BLANK_W) ? uart_led_pkg::BLANK : uart_led_pkg::DRIVE;

    anode_nxt      = ANODE_OFF;
    char_valid_nxt = 1'b0;
    if (state_nxt == uart_led_pkg::DRIVE) begin
      anode_nxt      = ~(4'b1000 >> digit_nxt);
      char_valid_nxt = 1'b1;
    end

    scroll_act = scroll_en && (count > 5'(NUM_DIGITS));
    frame_nxt  = frame_cnt;
    offset_nxt = offset;
    if (!scroll_act) begin
      frame_nxt  = '0;
      offset_nxt = '0;
    end else if (frame_wrap) begin
      if (frame_cnt == SCROLL_LAST) begin
        frame_nxt  = '0;
        offset_nxt = (offset + 5'd1 == count) ? '0 : offset + 5'd1;
      end else begin
        frame_nxt = frame_cnt + 16'd1;
      end
    end
    if (clear) offset_nxt = '0;

    // offset < count and digit <= 3, so one conditional subtract suffices
    // whenever the digit is actually populated. The next offset is used so
    // a scroll step shows up at the slot-0 start right after the wrap.
    sel_sum  = offset_nxt + {3'b000, digit_nxt};
    sel_idx  = (sel_sum >= count) ? 4'(sel_sum - count) : sel_sum[3:0];
    rd_addr  = rd_ptr + sel_idx;
    char_nxt = ({3'b000, digit_nxt} < count) ? rd_data : CHAR_BLANK;
  end

  // Scan registers: outputs always agree with the registered prescaler
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      psc        <= '0;
      digit      <= '0;
      state      <= uart_led_pkg::BLANK;
      frame_cnt  <= '0;
      offset     <= '0;
      anode      <= ANODE_OFF;
      char_valid <= 1'b0;
      char_out   <= CHAR_BLANK;
    end else begin
      psc        <= psc_nxt;
      digit      <= digit_nxt;
      state      <= state_nxt;
      frame_cnt  <= frame_nxt;
      offset     <= offset_nxt;
      anode      <= anode_nxt;
      char_valid <= char_valid_nxt;
      if (slot_wrap) char_out <= char_nxt;
    end
  end

endmodule
